counter_sequence_monitor: RTL and testbench

//  Read-side companion of the four-lane LED counter bank.
//  - Observes the 16-bit counter bus and checks that each nibble lane follows
//    its legal sequence: lane0 4-bit up, lane1 4-bit down, lane2 mod-10 up,

---
 rtl/counter_sequence_monitor_pkg.sv | 39 +++
 rtl/counter_sequence_monitor_if.sv | 33 +++
 rtl/counter_sequence_monitor_lane.sv | 42 ++++
 rtl/counter_sequence_monitor.sv | 101 ++++++++++
 tb/tb_counter_sequence_monitor.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sequence_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_mon_pkg
//  Brief    : Shared mode codes, lane geometry and helpers for the counter
//             sequence monitor.
//  Revision : 1.0 - initial release
// ============================================================================
package counter_mon_pkg;

    localparam int LANE_W    = 4;
    localparam int NUM_LANES = 4;
    localparam int BUS_W     = LANE_W * NUM_LANES;

    // Mode code equals the lane index that produced the last legal step
    typedef enum logic [1:0] {
        MODE_UP4   = 2'd0,
        MODE_DN4   = 2'd1,
        MODE_MOD10 = 2'd2,
        MODE_MOD5  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    // Lowest set bit of a lane vector mapped onto its mode code
    function automatic mode_e lane_to_mode(input logic [NUM_LANES-1:0] lanes);
        mode_e m;
        m = MODE_UP4;
        if (lanes[3]) m = MODE_MOD5;
        if (lanes[2]) m = MODE_MOD10;
        if (lanes[1]) m = MODE_DN4;
        if (lanes[0]) m = MODE_UP4;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_sequence_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : counter_mon_if
//  Brief    : Counter bus plus monitor status outputs. The monitor sits on
//             the slave side; whoever drives the LED bus is the master.
//  Revision : 1.0 - initial release
// ============================================================================
interface counter_mon_if #(
    parameter int CNT_W = 16
);
    import counter_mon_pkg::*;

    logic [BUS_W-1:0] led_in;
    logic             clr;
    logic [1:0]       active_mode;
    logic             mode_valid;
    logic [3:0]       lane_err;
    logic             multi_err;
    logic             err_pulse;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output led_in, clr,
        input  active_mode, mode_valid, lane_err, multi_err, err_pulse, step_cnt
    );

    modport slave (
        input  led_in, clr,
        output active_mode, mode_valid, lane_err, multi_err, err_pulse, step_cnt
    );

endinterface
`default_nettype wire

// File: rtl/counter_sequence_monitor_lane.sv
`default_nettype none
// ============================================================================
//  Module   : lane_seq_checker
//  Brief    : Combinational check of one nibble lane against its legal
//             up/down modulo sequence.
//  Revision : 1.0 - initial release
// ============================================================================
module lane_seq_checker
    import counter_mon_pkg::*;
#(
    parameter int   MODULUS = 16,
    parameter dir_e DIR     = DIR_UP
) (
    input  logic [LANE_W-1:0] prev,
    input  logic [LANE_W-1:0] cur,
    output logic              chg,
    output logic              step_ok,
    output logic              range_ok
);

    localparam logic [LANE_W-1:0] c_max = LANE_W'(MODULUS - 1);
    localparam logic [LANE_W:0]   c_mod = (LANE_W + 1)'(MODULUS);

    logic [LANE_W-1:0] w_nxt;

    // Legal successor of prev; for a full 16-state lane c_max is 15 so the
    // explicit wrap coincides with natural 4-bit overflow
    always_comb begin
        w_nxt = '0;
        if (DIR == DIR_UP) begin
            w_nxt = (prev == c_max) ? '0 : prev + 1'b1;
        end else begin
            w_nxt = (prev == '0) ? c_max : prev - 1'b1;
        end
    end

    assign chg      = (prev != cur);
    assign step_ok  = !chg || (cur == w_nxt);
    assign range_ok = ({1'b0, cur} < c_mod);

endmodule
`default_nettype wire

// File: rtl/counter_sequence_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : counter_sequence_monitor
//  Brief    : Watches the four-lane LED counter bus, records the lane of the
//             last legal step, counts legal steps and flags illegal steps,
//             out-of-range values and simultaneous multi-lane changes.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_sequence_monitor
    import counter_mon_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int MOD_UP = 10,
    parameter int MOD_DN = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    counter_mon_if.slave  bus
);

    logic [BUS_W-1:0]     r_prev;
    logic                 r_primed;
    logic [1:0]           r_active_mode;
    logic                 r_mode_valid;
    logic [NUM_LANES-1:0] r_lane_err;
    logic                 r_multi_err;
    logic                 r_err_pulse;
    logic [CNT_W-1:0]     r_step_cnt;

    logic [NUM_LANES-1:0] w_chg;
    logic [NUM_LANES-1:0] w_step_ok;
    logic [NUM_LANES-1:0] w_range_ok;
    logic [NUM_LANES-1:0] w_lane_bad;
    logic                 w_multi;
    logic                 w_any_err;
    logic                 w_legal;
    logic [CNT_W-1:0]     w_cnt_base;
    logic [CNT_W-1:0]     w_cnt_next;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int   LANE_MOD = (i < 2) ? (1 << LANE_W) : ((i == 2) ? MOD_UP : MOD_DN);
        localparam dir_e LANE_DIR = (i == 1 || i == 3) ? DIR_DN : DIR_UP;

        lane_seq_checker #(
            .MODULUS (LANE_MOD),
            .DIR     (LANE_DIR)
        ) u_chk (
            .prev     (r_prev[i*LANE_W +: LANE_W]),
            .cur      (bus.led_in[i*LANE_W +: LANE_W]),
            .chg      (w_chg[i]),
            .step_ok  (w_step_ok[i]),
            .range_ok (w_range_ok[i])
        );
    end

    // A lane is bad if it stepped illegally or now sits outside its range
    assign w_lane_bad = ~w_step_ok | ~w_range_ok;
    assign w_multi    = ($countones(w_chg) > 1);
    assign w_any_err  = (|w_lane_bad) || w_multi;
    // Exactly one lane moved and that lane landed on a legal, in-range value
    assign w_legal    = $onehot(w_chg) && (|(w_chg & w_step_ok & w_range_ok));
    assign w_cnt_base = bus.clr ? '0 : r_step_cnt;
    assign w_cnt_next = (w_legal && (w_cnt_base != '1)) ? w_cnt_base + 1'b1 : w_cnt_base;

    // Prime on the first edge after reset, then check every edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev        <= '0;
            r_primed      <= 1'b0;
            r_active_mode <= '0;
            r_mode_valid  <= 1'b0;
            r_lane_err    <= '0;
            r_multi_err   <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_step_cnt    <= '0;
        end else if (!r_primed) begin
            r_prev   <= bus.led_in;
            r_primed <= 1'b1;
        end else begin
            r_prev      <= bus.led_in;
            r_err_pulse <= w_any_err;
            // New errors win over a simultaneous clear
            r_lane_err  <= (bus.clr ? '0 : r_lane_err) | w_lane_bad;
            r_multi_err <= (bus.clr ? 1'b0 : r_multi_err) | w_multi;
            r_step_cnt  <= w_cnt_next;
            if (w_legal) begin
                r_active_mode <= lane_to_mode(w_chg);
                r_mode_valid  <= 1'b1;
            end
        end
    end

    assign bus.active_mode = r_active_mode;
    assign bus.mode_valid  = r_mode_valid;
    assign bus.lane_err    = r_lane_err;
    assign bus.multi_err   = r_multi_err;
    assign bus.err_pulse   = r_err_pulse;
    assign bus.step_cnt    = r_step_cnt;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequence_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_sequence_monitor
//  Brief    : Directed scenarios plus randomized bus traffic for the counter
//             sequence monitor, checked against a lane-rule reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_sequence_monitor;

    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;

    counter_mon_if #(.CNT_W(CNT_W)) bus ();

    counter_sequence_monitor #(
        .CNT_W  (CNT_W),
        .MOD_UP (10),
        .MOD_DN (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state, kept as plain integers per lane
    int       m_prev [4];
    bit       m_primed;
    bit [3:0] m_lane_err;
    bit       m_multi;
    bit       m_pulse;
    bit       m_valid;
    int       m_mode;
    int       m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int legal_next(input int lane, input int p);
        case (lane)
            0:       return (p + 1) % 16;
            1:       return (p + 15) % 16;
            2:       return (p == 9) ? 0 : (p + 1) % 16;
            default: return (p == 0) ? 4 : p - 1;
        endcase
    endfunction

    function automatic logic [15:0] model_bus();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'(m_prev[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_prev[i] = 0;
        m_primed   = 1'b0;
        m_lane_err = '0;
        m_multi    = 1'b0;
        m_pulse    = 1'b0;
        m_valid    = 1'b0;
        m_mode     = 0;
        m_cnt      = 0;
    endtask

    task automatic model_edge(input logic [15:0] led, input bit c);
        int       cur [4];
        int       nchg;
        int       last;
        bit [3:0] bad;
        nchg = 0;
        last = 0;
        bad  = '0;
        for (int i = 0; i < 4; i++) cur[i] = int'(led[4*i +: 4]);
        if (!m_primed) begin
            m_prev   = cur;
            m_primed = 1'b1;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (cur[i] != m_prev[i]) begin
                nchg++;
                last = i;
                if (cur[i] != legal_next(i, m_prev[i])) bad[i] = 1'b1;
            end
        end
        if (cur[2] >= 10) bad[2] = 1'b1;
        if (cur[3] >= 5)  bad[3] = 1'b1;
        if (c) begin
            m_lane_err = '0;
            m_multi    = 1'b0;
            m_cnt      = 0;
        end
        m_lane_err |= bad;
        if (nchg > 1) m_multi = 1'b1;
        m_pulse = (bad != 0) || (nchg > 1);
        if (nchg == 1 && !bad[last]) begin
            m_mode  = last;
            m_valid = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        m_prev = cur;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".active_mode"}, 32'(bus.active_mode), 32'(m_mode));
        check({tag, ".mode_valid"},  32'(bus.mode_valid),  32'(m_valid));
        check({tag, ".lane_err"},    32'(bus.lane_err),    32'(m_lane_err));
        check({tag, ".multi_err"},   32'(bus.multi_err),   32'(m_multi));
        check({tag, ".err_pulse"},   32'(bus.err_pulse),   32'(m_pulse));
        check({tag, ".step_cnt"},    32'(bus.step_cnt),    32'(m_cnt));
    endtask

    task automatic apply(input logic [15:0] led, input bit c, input string tag);
        @(negedge clk);
        bus.led_in = led;
        bus.clr    = c;
        @(posedge clk);
        model_edge(led, c);
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous assert away from the clock edge, release at a falling
    // edge, then the prime edge with led_rel on the bus
    task automatic do_reset(input logic [15:0] led_rst, input logic [15:0] led_rel);
        @(posedge clk);
        #3;
        bus.led_in = led_rst;
        bus.clr    = 1'b0;
        rst_n      = 1'b0;
        model_reset();
        #1;
        check_outputs("reset_async");
        repeat (2) @(negedge clk);
        bus.led_in = led_rel;
        rst_n      = 1'b1;
        @(posedge clk);
        model_edge(led_rel, 1'b0);
        #1;
        check_outputs("prime");
    endtask

    initial begin
        logic [15:0] led;
        int          r;
        int          ln;
        int          ln2;
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        bus.led_in = '0;
        bus.clr    = 1'b0;
        model_reset();

        // Idle bus after reset
        do_reset(16'h0000, 16'h0000);
        repeat (3) apply(16'h0000, 1'b0, "idle");
        check("idle_valid", 32'(bus.mode_valid), 32'd0);

        // Lane0 full up count including 15->0 wrap
        for (int v = 1; v <= 16; v++) apply(16'(v % 16), 1'b0, "lane0_up");
        check("lane0_cnt",  32'(bus.step_cnt),    32'd16);
        check("lane0_mode", 32'(bus.active_mode), 32'd0);
        check("lane0_err",  32'(bus.lane_err),    32'd0);

        // Lane3 mod-5 down with 0->4 wrap, then an illegal 7
        apply(16'h0000, 1'b1, "lane3_clr");
        for (int v = 4; v >= 0; v--) apply(16'(v << 12), 1'b0, "lane3_dn");
        check("lane3_cnt",  32'(bus.step_cnt),    32'd5);
        check("lane3_mode", 32'(bus.active_mode), 32'd3);
        apply(16'h7000, 1'b0, "lane3_bad");
        check("lane3_err",   32'(bus.lane_err[3]), 32'd1);
        check("lane3_pulse", 32'(bus.err_pulse),   32'd1);

        // Lane2 9->5 jump, then a clean clear
        do_reset(16'h0000, 16'h0800);
        apply(16'h0900, 1'b0, "lane2_up");
        apply(16'h0500, 1'b0, "lane2_jump");
        check("lane2_err", 32'(bus.lane_err[2]), 32'd1);
        apply(16'h0500, 1'b1, "lane2_clr");
        check("clr_err",  32'(bus.lane_err),    32'd0);
        check("clr_cnt",  32'(bus.step_cnt),    32'd0);
        check("clr_mode", 32'(bus.active_mode), 32'd2);

        // Two lanes changing together
        do_reset(16'h0000, 16'h0000);
        apply(16'h0011, 1'b0, "multi");
        check("multi_flag", 32'(bus.multi_err), 32'd1);
        check("multi_cnt",  32'(bus.step_cnt),  32'd0);

        // Mid-run reset, re-prime on 9 and step down to 8
        do_reset(16'h0000, 16'h0070);
        apply(16'h0060, 1'b0, "lane1_dn");
        do_reset(16'h0060, 16'h0090);
        check("reprime_err", 32'(bus.lane_err), 32'd0);
        apply(16'h0080, 1'b0, "reprime_step");
        check("reprime_cnt",  32'(bus.step_cnt),    32'd1);
        check("reprime_mode", 32'(bus.active_mode), 32'd1);

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            r   = $urandom_range(0, 199);
            led = model_bus();
            ln  = $urandom_range(0, 3);
            if (r < 120) begin
                led[4*ln +: 4] = 4'(legal_next(ln, m_prev[ln]));
            end else if (r < 140) begin
                // hold
            end else if (r < 155) begin
                ln2 = (ln + $urandom_range(1, 3)) % 4;
                led[4*ln +: 4]  = 4'(legal_next(ln, m_prev[ln]));
                led[4*ln2 +: 4] = 4'(legal_next(ln2, m_prev[ln2]));
            end else if (r < 175) begin
                led[4*ln +: 4] = 4'($urandom_range(0, 15));
            end else if (r < 190) begin
                led = 16'($urandom);
            end else if (r < 198) begin
                led[2*4 +: 4] = 4'($urandom_range(0, 9));
                led[3*4 +: 4] = 4'($urandom_range(0, 4));
            end
            if (r == 199) begin
                do_reset(led, 16'($urandom) & 16'h4FFF);
            end else begin
                apply(led, ($urandom_range(0, 15) == 0), "random");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
